// File: rtl/wdt_supervisor.sv
// wdt_supervisor: shared active-low reset generator with per-channel windowed watchdogs.
// Holds rst_n low for TP cycles after power-up, manual reset or any watchdog trip.
module wdt_supervisor #(
    parameter int CH    = 4,
    parameter int CNT_W = 24,
    parameter int TP    = 2000,
    parameter int TD    = 16000,
    parameter int TW    = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mr_n,
    input  logic [CH-1:0] wdi,
    input  logic [CH-1:0] ch_en,
    input  logic          fault_clr,
    output logic          rst_n,
    output logic [CH-1:0] fault,
    output logic [7:0]    trip_cnt
);

    typedef enum logic {
        HOLD = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(TP - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TD - 1);
    localparam logic [CNT_W-1:0] WIN_LAST     = CNT_W'((TW > 0) ? TW - 1 : 0);
    localparam bit               WIN_EN       = (TW > 0);

    state_e           state_q;
    logic [CNT_W-1:0] hcnt_q;
    logic [CNT_W-1:0] cnt_q [CH];
    logic [CNT_W-1:0] cnt_d [CH];
    logic             mrSync1_q;
    logic             mrSync2_q;
    logic [CH-1:0]    wdiSync1_q;
    logic [CH-1:0]    wdiSync2_q;
    logic [CH-1:0]    prev_q;
    logic             rstN_q;
    logic [CH-1:0]    fault_q;
    logic [7:0]       tripCnt_q;
    logic [CH-1:0]    kick;
    logic [CH-1:0]    chFault;

    assign kick = wdiSync2_q ^ prev_q;

    // A kick inside the early window is a fault; a kick on the timeout edge still rescues the channel.
    always_comb begin
        chFault = '0;
        for (int i = 0; i < CH; i++) begin
            cnt_d[i] = cnt_q[i] + 1'b1;
            if (!ch_en[i]) begin
                cnt_d[i] = '0;
            end else if (kick[i]) begin
                if (WIN_EN && (cnt_q[i] <= WIN_LAST)) begin
                    chFault[i] = 1'b1;
                end else begin
                    cnt_d[i] = '0;
                end
            end else if (cnt_q[i] == TIMEOUT_LAST) begin
                chFault[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= HOLD;
            hcnt_q     <= '0;
            mrSync1_q  <= 1'b0;
            mrSync2_q  <= 1'b0;
            wdiSync1_q <= '0;
            wdiSync2_q <= '0;
            prev_q     <= '0;
            rstN_q     <= 1'b0;
            fault_q    <= '0;
            tripCnt_q  <= '0;
            for (int i = 0; i < CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            mrSync1_q  <= mr_n;
            mrSync2_q  <= mrSync1_q;
            wdiSync1_q <= wdi;
            wdiSync2_q <= wdiSync1_q;
            prev_q     <= wdiSync2_q;
            if (fault_clr) begin
                fault_q <= '0;
            end
            case (state_q)
                HOLD: begin
                    if (!mrSync2_q) begin
                        hcnt_q <= '0;
                    end else if (hcnt_q == HOLD_LAST) begin
                        state_q <= RUN;
                        rstN_q  <= 1'b1;
                        for (int i = 0; i < CH; i++) begin
                            cnt_q[i] <= '0;
                        end
                    end else begin
                        hcnt_q <= hcnt_q + 1'b1;
                    end
                end
                RUN: begin
                    // Manual reset outranks any watchdog fault on the same edge.
                    if (!mrSync2_q) begin
                        state_q <= HOLD;
                        hcnt_q  <= '0;
                        rstN_q  <= 1'b0;
                    end else if (|chFault) begin
                        fault_q <= (fault_clr ? '0 : fault_q) | chFault;
                        if (tripCnt_q != 8'hFF) begin
                            tripCnt_q <= tripCnt_q + 1'b1;
                        end
                        state_q <= HOLD;
                        hcnt_q  <= '0;
                        rstN_q  <= 1'b0;
                    end else begin
                        for (int i = 0; i < CH; i++) begin
                            cnt_q[i] <= cnt_d[i];
                        end
                    end
                end
                default: state_q <= HOLD;
            endcase
        end
    end

    assign rst_n    = rstN_q;
    assign fault    = fault_q;
    assign trip_cnt = tripCnt_q;

endmodule

// File: tb/tb_wdt_supervisor.sv
// Bench for wdt_supervisor: directed scenarios plus random kicks against a timestamp-based model.
module tb_wdt_supervisor;

    localparam int CH    = 2;
    localparam int CNT_W = 8;
    localparam int TP    = 4;
    localparam int TD    = 10;
    localparam int TW    = 3;
    localparam int HIST  = 16384;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          mr_n = 1'b1;
    logic          fault_clr = 1'b0;
    logic [CH-1:0] wdi = '0;
    logic [CH-1:0] ch_en = '0;
    logic          rst_n;
    logic [CH-1:0] fault;
    logic [7:0]    trip_cnt;

    int checks = 0;
    int errors = 0;

    // Model: edge index since rst release, the edge each channel last restarted its timer,
    // and the input history so synchronizer latency is a plain index offset.
    int            edgeNo;
    logic          expRstN;
    logic [CH-1:0] expFault;
    int            expTrip;
    int            holdEnd;
    int            lastRef [CH];
    logic [CH-1:0] wdiHist [HIST];
    logic          mrHist [HIST];

    wdt_supervisor #(
        .CH(CH), .CNT_W(CNT_W), .TP(TP), .TD(TD), .TW(TW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mr_n(mr_n),
        .wdi(wdi),
        .ch_en(ch_en),
        .fault_clr(fault_clr),
        .rst_n(rst_n),
        .fault(fault),
        .trip_cnt(trip_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [CH-1:0] wdiAt(input int e);
        return (e >= 1) ? wdiHist[e] : '0;
    endfunction

    task automatic modelEdge(input logic [CH-1:0] en, input logic clr);
        int            k;
        logic          mrLow;
        logic [CH-1:0] nowW;
        logic [CH-1:0] oldW;
        logic [CH-1:0] trips;
        logic [CH-1:0] nextFault;
        k         = edgeNo;
        mrLow     = (k <= 2) ? 1'b1 : !mrHist[k-2];
        nowW      = wdiAt(k - 2);
        oldW      = wdiAt(k - 3);
        trips     = '0;
        nextFault = clr ? '0 : expFault;
        if (mrLow) begin
            expRstN = 1'b0;
            holdEnd = k + TP;
        end else if (!expRstN) begin
            if (k == holdEnd) begin
                expRstN = 1'b1;
                for (int i = 0; i < CH; i++) lastRef[i] = k;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (!en[i]) begin
                    lastRef[i] = k;
                end else if (nowW[i] != oldW[i]) begin
                    if (TW > 0 && (k - lastRef[i]) <= TW) trips[i] = 1'b1;
                    else lastRef[i] = k;
                end else if ((k - lastRef[i]) == TD) begin
                    trips[i] = 1'b1;
                end
            end
            if (trips != '0) begin
                nextFault = nextFault | trips;
                if (expTrip < 255) expTrip++;
                expRstN = 1'b0;
                holdEnd = k + TP;
            end
        end
        expFault = nextFault;
    endtask

    task automatic applyStimulus();
        logic [CH-1:0] en;
        logic          clr;
        wdiHist[edgeNo + 1] = wdi;
        mrHist[edgeNo + 1]  = mr_n;
        en  = ch_en;
        clr = fault_clr;
        @(posedge clk);
        #1;
        edgeNo++;
        modelEdge(en, clr);
    endtask

    task automatic applyReset(input logic [CH-1:0] en);
        rst       = 1'b1;
        wdi       = '0;
        mr_n      = 1'b1;
        fault_clr = 1'b0;
        ch_en     = en;
        repeat (2) @(posedge clk);
        #1;
        edgeNo   = 0;
        expRstN  = 1'b0;
        expFault = '0;
        expTrip  = 0;
        holdEnd  = TP;
        for (int i = 0; i < CH; i++) lastRef[i] = 0;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        checks++;
        if (rst_n !== 1'b0 || fault !== 2'b00 || trip_cnt !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_values: got rst_n=%b fault=%b trip=%0d, want 0 00 0", rst_n, fault, trip_cnt);
        end
    endtask

    task automatic test_power_up();
        applyReset(2'b00);
        for (int e = 1; e <= 7; e++) begin
            logic want;
            applyStimulus();
            want = (e >= TP + 2);
            checks++;
            if (rst_n !== want || fault !== 2'b00 || trip_cnt !== 8'd0) begin
                errors++;
                $display("[TB] FAIL power_up edge %0d: got rst_n=%b fault=%b trip=%0d, want rst_n=%b 00 0", e, rst_n, fault, trip_cnt, want);
            end
            checks++;
            if (rst_n !== expRstN) begin
                errors++;
                $display("[TB] FAIL power_up_model edge %0d: got rst_n=%b, want %b", e, rst_n, expRstN);
            end
        end
    endtask

    task automatic test_timeout();
        applyReset(2'b01);
        repeat (6) applyStimulus();
        for (int e = 1; e <= 14; e++) begin
            logic          wantRst;
            logic [CH-1:0] wantFault;
            logic [7:0]    wantTrip;
            applyStimulus();
            wantRst   = (e < 10) || (e >= 14);
            wantFault = (e >= 10) ? 2'b01 : 2'b00;
            wantTrip  = (e >= 10) ? 8'd1 : 8'd0;
            checks++;
            if (rst_n !== wantRst || fault !== wantFault || trip_cnt !== wantTrip) begin
                errors++;
                $display("[TB] FAIL timeout +%0d: got rst_n=%b fault=%b trip=%0d, want %b %b %0d", e, rst_n, fault, trip_cnt, wantRst, wantFault, wantTrip);
            end
            checks++;
            if (rst_n !== expRstN || fault !== expFault || trip_cnt !== 8'(expTrip)) begin
                errors++;
                $display("[TB] FAIL timeout_model +%0d: got %b %b %0d, want %b %b %0d", e, rst_n, fault, trip_cnt, expRstN, expFault, expTrip);
            end
        end
    endtask

    task automatic test_periodic_kicks();
        applyReset(2'b01);
        repeat (6) applyStimulus();
        for (int c = 0; c < 100; c++) begin
            if ((edgeNo - 6) % 6 == 3) wdi[0] = ~wdi[0];
            applyStimulus();
            checks++;
            if (rst_n !== 1'b1 || fault !== 2'b00 || rst_n !== expRstN || fault !== expFault) begin
                errors++;
                $display("[TB] FAIL periodic edge %0d: got rst_n=%b fault=%b, want 1 00 (model %b %b)", edgeNo, rst_n, fault, expRstN, expFault);
            end
        end
    endtask

    task automatic test_window();
        applyReset(2'b01);
        repeat (6) applyStimulus();
        while (edgeNo < 17) begin
            if (edgeNo == 8 || edgeNo == 10) wdi[0] = ~wdi[0];
            applyStimulus();
            if (edgeNo <= 13) begin
                logic wantRst;
                wantRst = (edgeNo < 13);
                checks++;
                if (rst_n !== wantRst || fault !== (wantRst ? 2'b00 : 2'b01) || trip_cnt !== (wantRst ? 8'd0 : 8'd1)) begin
                    errors++;
                    $display("[TB] FAIL window_early edge %0d: got rst_n=%b fault=%b trip=%0d", edgeNo, rst_n, fault, trip_cnt);
                end
            end
        end
        while (edgeNo < 30) begin
            logic wantRst;
            if (edgeNo == 20 || edgeNo == 24 || edgeNo == 27) wdi[0] = ~wdi[0];
            applyStimulus();
            wantRst = (edgeNo < 30);
            checks++;
            if (rst_n !== wantRst || fault !== 2'b01 || trip_cnt !== (wantRst ? 8'd1 : 8'd2)) begin
                errors++;
                $display("[TB] FAIL window_late edge %0d: got rst_n=%b fault=%b trip=%0d, want rst_n=%b", edgeNo, rst_n, fault, trip_cnt, wantRst);
            end
            checks++;
            if (rst_n !== expRstN || fault !== expFault || trip_cnt !== 8'(expTrip)) begin
                errors++;
                $display("[TB] FAIL window_model edge %0d: got %b %b %0d, want %b %b %0d", edgeNo, rst_n, fault, trip_cnt, expRstN, expFault, expTrip);
            end
        end
    endtask

    task automatic test_manual_reset();
        applyReset(2'b01);
        repeat (6) applyStimulus();
        while (edgeNo < 22) begin
            logic wantRst;
            if (edgeNo == 13) mr_n = 1'b0;
            if (edgeNo == 16) mr_n = 1'b1;
            applyStimulus();
            wantRst = (edgeNo < 16) || (edgeNo >= 22);
            checks++;
            if (rst_n !== wantRst || fault !== 2'b00 || trip_cnt !== 8'd0) begin
                errors++;
                $display("[TB] FAIL manual_reset edge %0d: got rst_n=%b fault=%b trip=%0d, want %b 00 0", edgeNo, rst_n, fault, trip_cnt, wantRst);
            end
            checks++;
            if (rst_n !== expRstN || fault !== expFault || trip_cnt !== 8'(expTrip)) begin
                errors++;
                $display("[TB] FAIL manual_model edge %0d: got %b %b %0d, want %b %b %0d", edgeNo, rst_n, fault, trip_cnt, expRstN, expFault, expTrip);
            end
        end
    endtask

    task automatic test_sticky_clear();
        applyReset(2'b01);
        while (edgeNo < 31) begin
            if (edgeNo == 16) ch_en = 2'b11;
            if (edgeNo == 23) wdi[0] = ~wdi[0];
            fault_clr = (edgeNo == 29);
            applyStimulus();
            if (edgeNo == 16) begin
                checks++;
                if (fault !== 2'b01 || trip_cnt !== 8'd1) begin
                    errors++;
                    $display("[TB] FAIL sticky_first: got fault=%b trip=%0d, want 01 1", fault, trip_cnt);
                end
            end
            if (edgeNo == 30) begin
                checks++;
                if (fault !== 2'b10 || trip_cnt !== 8'd2 || rst_n !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL set_beats_clear: got fault=%b trip=%0d rst_n=%b, want 10 2 0", fault, trip_cnt, rst_n);
                end
            end
            checks++;
            if (rst_n !== expRstN || fault !== expFault || trip_cnt !== 8'(expTrip)) begin
                errors++;
                $display("[TB] FAIL sticky_model edge %0d: got %b %b %0d, want %b %b %0d", edgeNo, rst_n, fault, trip_cnt, expRstN, expFault, expTrip);
            end
        end
        fault_clr = 1'b0;
    endtask

    task automatic test_saturation();
        applyReset(2'b01);
        while (edgeNo < 4230) begin
            applyStimulus();
            if (edgeNo == 3558 || edgeNo == 3572) begin
                logic [7:0] want;
                want = (edgeNo == 3558) ? 8'd254 : 8'd255;
                checks++;
                if (trip_cnt !== want) begin
                    errors++;
                    $display("[TB] FAIL trip_count edge %0d: got %0d, want %0d", edgeNo, trip_cnt, want);
                end
            end
            checks++;
            if (rst_n !== expRstN || fault !== expFault || trip_cnt !== 8'(expTrip)) begin
                errors++;
                $display("[TB] FAIL saturation_model edge %0d: got %b %b %0d, want %b %b %0d", edgeNo, rst_n, fault, trip_cnt, expRstN, expFault, expTrip);
            end
        end
        checks++;
        if (trip_cnt !== 8'd255) begin
            errors++;
            $display("[TB] FAIL trip_saturated: got %0d, want 255", trip_cnt);
        end
    endtask

    task automatic test_random();
        int mrLeft;
        mrLeft = 0;
        applyReset(CH'($urandom));
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < CH; i++) begin
                if ($urandom_range(0, 6) == 0) wdi[i] = ~wdi[i];
            end
            if ($urandom_range(0, 99) == 0) ch_en = CH'($urandom);
            fault_clr = ($urandom_range(0, 29) == 0);
            if (mrLeft > 0) begin
                mrLeft--;
                mr_n = 1'b0;
            end else if ($urandom_range(0, 299) == 0) begin
                mrLeft = $urandom_range(0, 3);
                mr_n   = 1'b0;
            end else begin
                mr_n = 1'b1;
            end
            applyStimulus();
            checks++;
            if (rst_n !== expRstN || fault !== expFault || trip_cnt !== 8'(expTrip)) begin
                errors++;
                $display("[TB] FAIL random_model edge %0d: got %b %b %0d, want %b %b %0d", edgeNo, rst_n, fault, trip_cnt, expRstN, expFault, expTrip);
            end
        end
        fault_clr = 1'b0;
        mr_n      = 1'b1;
    endtask

    task automatic test_async_reset();
        applyReset(2'b01);
        while (edgeNo < 20) applyStimulus();
        checks++;
        if (fault !== 2'b01 || trip_cnt !== 8'd1) begin
            errors++;
            $display("[TB] FAIL async_setup: got fault=%b trip=%0d, want 01 1", fault, trip_cnt);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (rst_n !== 1'b0 || fault !== 2'b00 || trip_cnt !== 8'd0) begin
            errors++;
            $display("[TB] FAIL async_reset: got rst_n=%b fault=%b trip=%0d, want 0 00 0", rst_n, fault, trip_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_timeout();
        test_periodic_kicks();
        test_window();
        test_manual_reset();
        test_sticky_clear();
        test_saturation();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
